// File: rtl/mem_read_pkg.sv
// Shared encodings for the load path: access sizes, FSM states, lane offsets
// and the latched per-transaction control word.
package mem_read_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    SIZE_WORD  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_BYTE  = 2'b10,
    SIZE_VBYTE = 2'b11
  } rd_size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_CAPTURE = 2'b10
  } state_e;

  // Big-endian lane offsets: offset 0 is the most significant lane.
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;
  localparam logic [1:0] OFF_H0 = 2'd0;
  localparam logic [1:0] OFF_H2 = 2'd2;

  typedef struct packed {
    logic [1:0] offset;
    rd_size_e   size;
    logic       uns;
  } rd_ctl_t;

  function automatic logic is_misaligned(input rd_size_e size, input logic [1:0] off);
    return ((size == SIZE_WORD) && (off != OFF_B0)) ||
           ((size == SIZE_HALF) && off[0]);
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a memory word and extends it to 32 bits.
module load_align
  import mem_read_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  rd_size_e          size,
  input  logic              uns,
  output logic [DATA_W-1:0] value_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (offset)
      OFF_B0:  lane_b = word[31:24];
      OFF_B1:  lane_b = word[23:16];
      OFF_B2:  lane_b = word[15:8];
      OFF_B3:  lane_b = word[7:0];
      default: lane_b = word[7:0];
    endcase

    lane_h = (offset == OFF_H2) ? word[15:0] : word[31:16];

    value_c = word;
    case (size)
      SIZE_WORD:  value_c = word;
      SIZE_HALF:  value_c = uns ? DATA_W'(lane_h) : DATA_W'($signed(lane_h));
      SIZE_BYTE:  value_c = uns ? DATA_W'(lane_b) : DATA_W'($signed(lane_b));
      SIZE_VBYTE: value_c = DATA_W'(lane_b);
      default:    value_c = word;
    endcase
  end

endmodule

// File: rtl/mem_read_unit.sv
// Load unit: issues one aligned word read per accepted request, aligns/extends
// the returned data into mdr, and aborts on misalignment or memory timeout.
module mem_read_unit
  import mem_read_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_start,
  input  logic [DATA_W-1:0] rd_addr,
  input  logic [1:0]        rd_size,
  input  logic              rd_unsigned,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mdr,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              rd_misalign,
  output logic              rd_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  rd_ctl_t           ctl_q, ctl_d, start_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_addr_d, mdr_d, aligned_c;
  logic              mem_req_d, rd_busy_d, done_d, mis_d, to_d;

  assign start_c = '{offset: rd_addr[1:0], size: rd_size_e'(rd_size), uns: rd_unsigned};

  load_align u_align (
    .word    (mem_rdata),
    .offset  (ctl_q.offset),
    .size    (ctl_q.size),
    .uns     (ctl_q.uns),
    .value_c (aligned_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    ctl_d      = ctl_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr;
    mdr_d      = mdr;
    mem_req_d  = 1'b0;
    rd_busy_d  = 1'b0;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    to_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          if (is_misaligned(start_c.size, start_c.offset)) begin
            mis_d = 1'b1;
          end else begin
            state_d    = ST_REQ;
            ctl_d      = start_c;
            cnt_d      = '0;
            mem_addr_d = {rd_addr[DATA_W-1:2], 2'b00};
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d = ST_CAPTURE;
          mdr_d   = aligned_c;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    mem_req_d = (state_d == ST_REQ);
    rd_busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ctl_q       <= '0;
      cnt_q       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mdr         <= '0;
      rd_busy     <= 1'b0;
      rd_done     <= 1'b0;
      rd_misalign <= 1'b0;
      rd_timeout  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      cnt_q       <= cnt_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      mdr         <= mdr_d;
      rd_busy     <= rd_busy_d;
      rd_done     <= done_d;
      rd_misalign <= mis_d;
      rd_timeout  <= to_d;
    end
  end

endmodule
